phys_reg_file_mp: RTL and testbench

Parametrised multi-port physical register file with a per-entry ready scoreboard, for the out-of-order RISC-V core.
- Renamed destinations are marked not-ready at allocation and set ready on write-back from any of NUM_WB execution ports.
- Issue and dispatch logic read operands and ready bits through NUM_RD combinational read ports.
- On exception or mret, a multi-cycle restore sequencer reloads the architectural state and clears the speculative entries. This replaces a single-cycle bulk copy.

---
 rtl/prf_pkg.sv | 20 ++
 rtl/prf_restore_fsm.sv | 75 +++++++
 rtl/phys_reg_file_mp.sv | 121 ++++++++++++
 tb/tb_phys_reg_file_mp.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prf_pkg.sv
// Shared constants, restore-sequencer state encoding and sizing helper for the physical register file.
package prf_pkg;

  localparam int PRF_NUM_PREGS = 256;
  localparam int PRF_NUM_AREGS = 32;
  localparam int PRF_XLEN      = 32;
  localparam int PTAG_W        = $clog2(PRF_NUM_PREGS);

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    CLEAR,
    DONE
  } restore_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prf_restore_fsm.sv
// Restore sequencer: one COPY cycle, NUM_CHUNKS CLEAR cycles, one DONE pulse; req-to-done is NUM_CHUNKS+2 cycles.
// Requests arriving while busy are dropped; strobes and status outputs are all registered.
module prf_restore_fsm
  import prf_pkg::*;
#(
  parameter int NUM_CHUNKS = 7,
  parameter int CNT_W      = cnt_width(NUM_CHUNKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_restore_req,
  output logic             o_copy_en,
  output logic             o_clr_en,
  output logic [CNT_W-1:0] o_clr_chunk,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

  restore_state_e   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_copy;
  logic             r_clr;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_copy  <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_restore_req) begin
            r_state <= COPY;
            r_busy  <= 1'b1;
            r_copy  <= 1'b1;
          end
        end
        COPY: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          r_copy  <= 1'b0;
          r_clr   <= 1'b1;
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
            r_clr   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_copy_en   = r_copy;
  assign o_clr_en    = r_clr;
  assign o_clr_chunk = r_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with ready scoreboard; zero-latency reads, writes visible next cycle unless PRF_BYPASS_EN.
// No backpressure: write-back and allocation are silently dropped while a restore is in progress.
module phys_reg_file_mp
  import prf_pkg::*;
#(
  parameter int NUM_PREGS = PRF_NUM_PREGS,
  parameter int NUM_AREGS = PRF_NUM_AREGS,
  parameter int XLEN      = PRF_XLEN,
  parameter int NUM_WB    = 7,
  parameter int NUM_RD    = 12,
  parameter int CLR_LANES = 32,
  parameter int TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_valid,
  input  logic [TAG_W-1:0]          alloc_tag,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
  input  logic [NUM_WB*XLEN-1:0]    wb_data,
  input  logic [NUM_RD*TAG_W-1:0]   rd_tag,
  output logic [NUM_RD*XLEN-1:0]    rd_data,
  output logic [NUM_RD-1:0]         rd_ready,
  input  logic                      restore_req,
  input  logic [NUM_AREGS*XLEN-1:0] arch_data,
  output logic                      restore_busy,
  output logic                      restore_done
);

  localparam int NUM_CHUNKS = (NUM_PREGS - NUM_AREGS) / CLR_LANES;
  localparam int CNT_W      = cnt_width(NUM_CHUNKS);

  logic [NUM_PREGS-1:0][XLEN-1:0] r_data;
  logic [NUM_PREGS-1:0]           r_ready;

  logic             w_copy_en;
  logic             w_clr_en;
  logic [CNT_W-1:0] w_clr_chunk;
  logic [TAG_W-1:0] w_clr_base;
  logic             w_unused_arch;

  // Entry 0 is never restored, so its architectural slot is deliberately ignored.
  assign w_unused_arch = ^arch_data[XLEN-1:0];
  assign w_clr_base    = TAG_W'(NUM_AREGS) + TAG_W'(w_clr_chunk) * TAG_W'(CLR_LANES);

  prf_restore_fsm #(
    .NUM_CHUNKS (NUM_CHUNKS),
    .CNT_W      (CNT_W)
  ) u_restore_fsm (
    .clk           (clk),
    .rst           (reset),
    .i_restore_req (restore_req),
    .o_copy_en     (w_copy_en),
    .o_clr_en      (w_clr_en),
    .o_clr_chunk   (w_clr_chunk),
    .o_busy        (restore_busy),
    .o_done        (restore_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_ready <= '1;
    end else if (restore_busy) begin
      if (w_copy_en) begin
        for (int i = 1; i < NUM_AREGS; i++) begin
          r_data[i]  <= arch_data[i*XLEN +: XLEN];
          r_ready[i] <= 1'b1;
        end
      end
      if (w_clr_en) begin
        for (int j = 0; j < CLR_LANES; j++) begin
          r_data[w_clr_base + TAG_W'(j)]  <= '0;
          r_ready[w_clr_base + TAG_W'(j)] <= 1'b1;
        end
      end
    end else if (!restore_req) begin
      // Later NBAs override earlier ones: highest write-back port wins, allocation overrides ready.
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] != '0)) begin
          r_data[wb_tag[k*TAG_W +: TAG_W]]  <= wb_data[k*XLEN +: XLEN];
          r_ready[wb_tag[k*TAG_W +: TAG_W]] <= 1'b1;
        end
      end
      if (alloc_valid && (alloc_tag != '0)) begin
        r_ready[alloc_tag] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [TAG_W-1:0] w_tag;
    logic [XLEN-1:0]  w_dat;
    logic             w_rdy;

    assign w_tag = rd_tag[p*TAG_W +: TAG_W];

    always_comb begin
      w_dat = r_data[w_tag];
      w_rdy = r_ready[w_tag];
`ifdef PRF_BYPASS_EN
      if (!restore_busy) begin
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == w_tag)) begin
            w_dat = wb_data[k*XLEN +: XLEN];
            w_rdy = 1'b1;
          end
        end
      end
`endif
      if (w_tag == '0) begin
        w_dat = '0;
        w_rdy = 1'b1;
      end
    end

    assign rd_data[p*XLEN +: XLEN] = w_dat;
    assign rd_ready[p]             = w_rdy;
  end

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Directed bench for phys_reg_file_mp at default parameters; expectations follow PRF_BYPASS_EN when defined.
module tb_phys_reg_file_mp;

  localparam int NP = 256;
  localparam int NA = 32;
  localparam int XL = 32;
  localparam int NW = 7;
  localparam int NR = 12;
  localparam int TW = 8;
  localparam int NV = 14;
`ifdef PRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             alloc_valid;
  logic [TW-1:0]    alloc_tag;
  logic [NW-1:0]    wb_valid;
  logic [NW*TW-1:0] wb_tag;
  logic [NW*XL-1:0] wb_data;
  logic [NR*TW-1:0] rd_tag;
  logic [NR*XL-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic             restore_req;
  logic [NA*XL-1:0] arch_data;
  logic             restore_busy;
  logic             restore_done;

  int n_err;
  int n_chk;

  always #5 clk = ~clk;

  phys_reg_file_mp #(
    .NUM_PREGS (NP),
    .NUM_AREGS (NA),
    .XLEN      (XL),
    .NUM_WB    (NW),
    .NUM_RD    (NR),
    .CLR_LANES (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .restore_req  (restore_req),
    .arch_data    (arch_data),
    .restore_busy (restore_busy),
    .restore_done (restore_done)
  );

  typedef struct {
    bit          w0_v;
    int          w0_p;
    logic [7:0]  w0_t;
    logic [31:0] w0_d;
    bit          w1_v;
    int          w1_p;
    logic [7:0]  w1_t;
    logic [31:0] w1_d;
    bit          al_v;
    logic [7:0]  al_t;
    int          rp;
    logic [7:0]  rt;
    logic [31:0] ed;
    logic        er;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mk(bit w0v, int w0p, logic [7:0] w0t, logic [31:0] w0d,
                              bit w1v, int w1p, logic [7:0] w1t, logic [31:0] w1d,
                              bit alv, logic [7:0] alt, int rp, logic [7:0] rt,
                              logic [31:0] ed, logic er);
    vec_t v;
    v.w0_v = w0v; v.w0_p = w0p; v.w0_t = w0t; v.w0_d = w0d;
    v.w1_v = w1v; v.w1_p = w1p; v.w1_t = w1t; v.w1_d = w1d;
    v.al_v = alv; v.al_t = alt; v.rp = rp; v.rt = rt; v.ed = ed; v.er = er;
    return v;
  endfunction

  function automatic logic [XL-1:0] rdd(int p);
    return rd_data[p*XL +: XL];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0;
    alloc_tag   = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_data     = '0;
    rd_tag      = '0;
    restore_req = 1'b0;
  endtask

  task automatic set_wb(input int k, input logic [7:0] t, input logic [31:0] d);
    wb_valid[k]        = 1'b1;
    wb_tag[k*TW +: TW] = t;
    wb_data[k*XL +: XL] = d;
  endtask

  task automatic set_rd(input int p, input logic [7:0] t);
    rd_tag[p*TW +: TW] = t;
  endtask

  int          post_tag [8] = '{7, 0, 100, 50, 45, 31, 255, 40};
  logic [31:0] post_dat [8] = '{32'h107, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11F, 32'h0, 32'h0};

  initial begin
    n_err = 0;
    n_chk = 0;
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < NA; i++) arch_data[i*XL +: XL] = 32'h100 + i;

    vec[0]  = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  1,8'd40, 0,8'd40,  32'h0, 1'b1);
    vec[1]  = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  0,8'd0,  0,8'd40,  32'h0, 1'b0);
    vec[2]  = mk(1,3,8'd40,32'hDEADBEEF,  0,0,8'd0,32'h0,  0,8'd0,  0,8'd40,
                 BYP ? 32'hDEADBEEF : 32'h0, BYP);
    vec[3]  = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  0,8'd0,  0,8'd40,  32'hDEADBEEF, 1'b1);
    vec[4]  = mk(1,1,8'd60,32'h11,        1,5,8'd60,32'h55, 0,8'd0, 7,8'd60,
                 BYP ? 32'h55 : 32'h0, 1'b1);
    vec[5]  = mk(1,0,8'd60,32'h77,        0,0,8'd0,32'h0,  1,8'd60, 7,8'd60,
                 BYP ? 32'h77 : 32'h55, 1'b1);
    vec[6]  = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  0,8'd0,  7,8'd60,  32'h77, 1'b0);
    vec[7]  = mk(1,6,8'd0,32'h99,         0,0,8'd0,32'h0,  1,8'd0,  11,8'd0,  32'h0, 1'b1);
    vec[8]  = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  0,8'd0,  11,8'd0,  32'h0, 1'b1);
    vec[9]  = mk(1,2,8'd33,32'hCAFE,      0,0,8'd0,32'h0,  0,8'd0,  4,8'd33,
                 BYP ? 32'hCAFE : 32'h0, 1'b1);
    vec[10] = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  0,8'd0,  4,8'd33,  32'hCAFE, 1'b1);
    vec[11] = mk(1,4,8'd100,32'hABC,      0,0,8'd0,32'h0,  1,8'd50, 9,8'd100,
                 BYP ? 32'hABC : 32'h0, 1'b1);
    vec[12] = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  0,8'd0,  9,8'd100, 32'hABC, 1'b1);
    vec[13] = mk(0,0,8'd0,32'h0,          0,0,8'd0,32'h0,  0,8'd0,  3,8'd50,  32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    set_rd(0, 8'd0); set_rd(1, 8'd5); set_rd(2, 8'd200);
    #1;
    chk("rst_busy", {31'b0, restore_busy}, 32'h0);
    chk("rst_done", {31'b0, restore_done}, 32'h0);
    chk("rst_t0_dat", rdd(0), 32'h0);
    chk("rst_t0_rdy", {31'b0, rd_ready[0]}, 32'h1);
    chk("rst_t5_dat", rdd(1), 32'h0);
    chk("rst_t5_rdy", {31'b0, rd_ready[1]}, 32'h1);
    chk("rst_t200_dat", rdd(2), 32'h0);
    chk("rst_t200_rdy", {31'b0, rd_ready[2]}, 32'h1);

    for (int v = 0; v < NV; v++) begin
      tick();
      clear_inputs();
      if (vec[v].w0_v) set_wb(vec[v].w0_p, vec[v].w0_t, vec[v].w0_d);
      if (vec[v].w1_v) set_wb(vec[v].w1_p, vec[v].w1_t, vec[v].w1_d);
      alloc_valid = vec[v].al_v;
      alloc_tag   = vec[v].al_t;
      set_rd(vec[v].rp, vec[v].rt);
      #1;
      chk($sformatf("vec%0d_dat", v), rdd(vec[v].rp), vec[v].ed);
      chk($sformatf("vec%0d_rdy", v), {31'b0, rd_ready[vec[v].rp]}, {31'b0, vec[v].er});
    end

    // Restore request at cycle N, colliding with a write-back and an allocation.
    tick();
    clear_inputs();
    restore_req = 1'b1;
    set_wb(0, 8'd150, 32'h5555);
    alloc_valid = 1'b1;
    alloc_tag   = 8'd151;
    #1;
    chk("rs_n_busy", {31'b0, restore_busy}, 32'h0);

    tick();
    clear_inputs();
    set_rd(0, 8'd150); set_rd(1, 8'd151); set_rd(2, 8'd100);
    #1;
    chk("rs_c1_busy", {31'b0, restore_busy}, 32'h1);
    chk("rs_c1_done", {31'b0, restore_done}, 32'h0);
    chk("rs_drop_wb_dat", rdd(0), 32'h0);
    chk("rs_drop_al_rdy", {31'b0, rd_ready[1]}, 32'h1);
    chk("rs_live_dat", rdd(2), 32'hABC);

    for (int c = 2; c <= 9; c++) begin
      tick();
      clear_inputs();
      if (c == 5) begin
        set_wb(1, 8'd50, 32'h1234);
        alloc_valid = 1'b1;
        alloc_tag   = 8'd45;
      end
      #1;
      chk($sformatf("rs_c%0d_busy", c), {31'b0, restore_busy}, 32'h1);
      chk($sformatf("rs_c%0d_done", c), {31'b0, restore_done}, (c == 9) ? 32'h1 : 32'h0);
    end

    tick();
    clear_inputs();
    for (int p = 0; p < 8; p++) set_rd(p, post_tag[p][7:0]);
    #1;
    chk("rs_end_busy", {31'b0, restore_busy}, 32'h0);
    chk("rs_end_done", {31'b0, restore_done}, 32'h0);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("post_t%0d_dat", post_tag[p]), rdd(p), post_dat[p]);
      chk($sformatf("post_t%0d_rdy", post_tag[p]), {31'b0, rd_ready[p]}, 32'h1);
    end

    // Reset asserted in the middle of CLEAR.
    tick();
    clear_inputs();
    restore_req = 1'b1;
    tick();
    clear_inputs();
    tick();
    tick();
    set_rd(0, 8'd7); set_rd(1, 8'd31);
    #1;
    chk("mid_busy", {31'b0, restore_busy}, 32'h1);
    chk("mid_t7_dat", rdd(0), 32'h107);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, restore_busy}, 32'h0);
    chk("arst_done", {31'b0, restore_done}, 32'h0);
    chk("arst_t7_dat", rdd(0), 32'h0);
    chk("arst_t7_rdy", {31'b0, rd_ready[0]}, 32'h1);
    chk("arst_t31_dat", rdd(1), 32'h0);

    tick();
    reset = 1'b0;
    tick();
    clear_inputs();
    alloc_valid = 1'b1;
    alloc_tag   = 8'd40;
    set_rd(0, 8'd40);
    #1;
    chk("rec_t40_rdy0", {31'b0, rd_ready[0]}, 32'h1);
    tick();
    clear_inputs();
    set_rd(0, 8'd40);
    #1;
    chk("rec_t40_rdy1", {31'b0, rd_ready[0]}, 32'h0);
    chk("rec_busy", {31'b0, restore_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
